spram_arbiter: RTL and testbench
================================

# spram_arbiter

Two-port arbiter and sequencer for the single-port SPRAM (`ice40up5k_spram`). It shares the SPRAM between the CPU (port 0) and a secondary master such as a UART loader or DMA (port 1), each using the `req`/`ack`/`wr` handshake. It replaces direct CPU-to-SPRAM wiring in `top`: it registers the winning request, drives the SPRAM for exactly one access cycle, and returns read data with a single-cycle `ack`.

## Interface
Parameters:
- `ADDR_W`, default 14, word-address width to the SPRAM.
- `FIXED_PRIO`, default 0. 0 = round-robin; 1 = port 0 always wins ties.

Ports:
- `clk` in 1: system clock; all logic on the rising edge.
- `reset` in 1: synchronous, active-high reset (one clock; polarity and synchronicity are fixed).
- `p0_req`, `p1_req` in 1: transaction request; held high until `ack`.
- `p0_wr`, `p1_wr` in 1: 1 = write, 0 = read.
- `p0_be`, `p1_be` in 4: byte enables for writes.
- `p0_addr`, `p1_addr` in ADDR_W: word address.
- `p0_wdata`, `p1_wdata` in 32: write data.
- `p0_rdata`, `p1_rdata` out 32: read data; valid only while the matching `ack` = 1.
- `p0_ack`, `p1_ack` out 1: one-cycle completion pulse.
- `ram_addr` out ADDR_W: SPRAM address.
- `ram_wen` out 4: SPRAM byte write enables.
- `ram_wdata` out 32: SPRAM write data.
- `ram_rdata` in 32: SPRAM read data; 1-cycle latency after the address edge.
- `busy` out 1: high when the FSM is not IDLE.
- `grant` out 1: index of the port currently or last served.

## Operation
FSM with three states: IDLE → ACCESS → RESP → IDLE.

**IDLE**
- If no `req` is high, stay in IDLE.
- If exactly one port requests, grant it.
- If both request:
  - `FIXED_PRIO`=1: grant port 0.
  - `FIXED_PRIO`=0: grant `~last_grant`.
- On a grant, latch `addr`, `wr`, `be` and `wdata` of the winner into request registers, update `last_grant`, and go to ACCESS.

**ACCESS**
- `ram_addr` = latched address; `ram_wdata` = latched data.
- `ram_wen` = latched `be` if write, else 4'b0000.
- Unconditionally go to RESP.

**RESP**
- `ram_wen` = 0.
- Granted port's `ack` = 1 (combinational from state and grant).
- Granted port's `rdata` = `ram_rdata`.
- Go to IDLE.

**Outputs outside these cases**
- `ram_wen` = 0 in IDLE and RESP.
- `ram_addr` and `ram_wdata` hold the latched values; don't-care when `ram_wen` = 0.
- Non-granted `ack` = 0. `rdata` is don't-care when its `ack` is low.

**Edge cases**
- A write with `be` = 0 is a legal no-op and still acks.
- For writes, `rdata` during `ack` is undefined; the bench must not check it.
- If a requester drops `req` before `ack`, the transaction still completes and `ack` still pulses.
- A `req` arriving during ACCESS or RESP waits; it is evaluated in the next IDLE cycle.

## Timing
- Latency: `req` sampled high in IDLE at cycle 0 → SPRAM access in cycle 1 → `ack` and `rdata` in cycle 2.
- Throughput: one transaction per 3 cycles. Back-to-back: a requester may present its next transaction in the cycle after `ack`.
- `last_grant` updates at the end of the IDLE grant cycle. Round-robin alternates strictly while both ports request continuously.
- Reset, applied at any rising edge with `reset`=1:
  - state → IDLE, `last_grant` → 1 (port 0 wins the first tie), `busy` = 0, `grant` = 0.
  - Both `ack` = 0 and `ram_wen` = 0 from the cycle after that edge.
- Reset asserted on the edge that ends ACCESS: the SPRAM write on that same edge still commits. No `ack` is issued.
- Reset asserted during RESP: the current `ack` cycle is still visible (outputs are combinational), and the FSM returns to IDLE.

## Structure
- Package `fetchie_mem_pkg`:
  - `arb_state_t` enum {IDLE, ACCESS, RESP}.
  - `BE_NONE` = 4'b0000, `BE_ALL` = 4'b1111.
  - `SPRAM_ADDR_W` = 14.
- Sub-module `rr_arb2`: combinational two-requester arbiter.
  - Inputs: `req[1:0]`, `last_grant`, `fixed_prio`.
  - Outputs: `grant_valid`, `grant_idx`.
- Remainder of the block: FSM, request registers, output muxing. Target 150–250 lines.

## Test plan
- **Single read:** `p0_req`=1, `wr`=0, `addr`=0x0010, SPRAM preloaded with 0xDEADBEEF → `p0_ack`=1 exactly in cycle 2, `p0_rdata`=0xDEADBEEF, `ram_wen` never nonzero.
- **Byte write then read:** p1 writes `be`=4'b0011, `wdata`=0x1234ABCD to 0x0020 over 0xFFFFFFFF → `ram_wen`=4'b0011 only in the ACCESS cycle; a subsequent read returns 0xFFFFABCD.
- **Contention, round-robin:** both ports request continuously after reset → grants 0,1,0,1. Each `ack` is 3 cycles apart, and `p0_ack` and `p1_ack` are never high together.
- **Fixed priority:** `FIXED_PRIO`=1, both ports request continuously → only port 0 is served. Port 1 is served on the first IDLE cycle after `p0_req` drops.
- **Reset mid-write:** `reset` on the edge ending ACCESS of a write of 0x55AA55AA to 0x0003 → no `ack`. After release, a read of 0x0003 returns 0x55AA55AA; `busy`=0 and `ram_wen`=0 in the cycle after reset.
- **Early req drop:** p0 drops `req` during ACCESS → `p0_ack` still pulses in cycle 2. A pending p1 request is granted in the following IDLE cycle.

Source files
------------

// File: rtl/fetchie_mem_pkg.sv
// Shared types and constants for the SPRAM arbitration path.
// Imported by the arbiter, its port interface and the bench.
package fetchie_mem_pkg;

   localparam int unsigned SPRAM_ADDR_W = 14;

   localparam logic [3:0] BE_NONE = 4'b0000;
   localparam logic [3:0] BE_ALL  = 4'b1111;

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      RESP
   } arb_state_t;

   // Byte write enables presented to the SPRAM for one access cycle.
   function automatic logic [3:0] access_wen(input logic wr, input logic [3:0] be);
      return (wr ? BE_ALL : BE_NONE) & be;
   endfunction

endpackage

// File: rtl/spram_arbiter_if.sv
// One requester port of the SPRAM arbiter: req/ack/wr handshake plus data.
interface spram_arbiter_if
   import fetchie_mem_pkg::*;
#(
   parameter int unsigned ADDR_W = SPRAM_ADDR_W
);

   logic              req;
   logic              wr;
   logic [3:0]        be;
   logic [ADDR_W-1:0] addr;
   logic [31:0]       wdata;
   logic [31:0]       rdata;
   logic              ack;

   modport master (
      output req,
      output wr,
      output be,
      output addr,
      output wdata,
      input  rdata,
      input  ack
   );

   modport slave (
      input  req,
      input  wr,
      input  be,
      input  addr,
      input  wdata,
      output rdata,
      output ack
   );

endinterface

// File: rtl/rr_arb2.sv
// Combinational two-requester arbiter: round-robin on ties unless fixed_prio
// is set, in which case port 0 always wins a tie.
module rr_arb2 (
   input  logic [1:0] req,
   input  logic       last_grant,
   input  logic       fixed_prio,
   output logic       grant_valid,
   output logic       grant_idx
);

   always_comb begin
      grant_valid = |req;
      grant_idx   = 1'b0;
      case (req)
         2'b01:   grant_idx = 1'b0;
         2'b10:   grant_idx = 1'b1;
         2'b11:   grant_idx = fixed_prio ? 1'b0 : ~last_grant;
         default: grant_idx = 1'b0;
      endcase
   end

endmodule

// File: rtl/spram_arbiter.sv
// Shares the single-port SPRAM between two masters: registers the winning
// request, drives one access cycle, then returns read data with a 1-cycle ack.
module spram_arbiter
   import fetchie_mem_pkg::*;
#(
   parameter int unsigned ADDR_W     = SPRAM_ADDR_W,
   parameter int unsigned FIXED_PRIO = 0
) (
   input  logic              clk,
   input  logic              reset,
   spram_arbiter_if.slave    p0,
   spram_arbiter_if.slave    p1,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [3:0]        ram_wen,
   output logic [31:0]       ram_wdata,
   input  logic [31:0]       ram_rdata,
   output logic              busy,
   output logic              grant
);

   arb_state_t        state;
   arb_state_t        state_next;

   logic              last_grant;
   logic              grant_q;
   logic [ADDR_W-1:0] addr_q;
   logic              wr_q;
   logic [3:0]        be_q;
   logic [31:0]       wdata_q;

   logic              arb_valid;
   logic              arb_idx;
   logic              take;

   rr_arb2 u_arb (
      .req         ({p1.req, p0.req}),
      .last_grant  (last_grant),
      .fixed_prio  (FIXED_PRIO != 0),
      .grant_valid (arb_valid),
      .grant_idx   (arb_idx)
   );

   // A grant is taken only from IDLE; requests seen in ACCESS/RESP wait.
   assign take = (state == IDLE) && arb_valid && !reset;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (arb_valid) state_next = ACCESS;
         ACCESS:  state_next = RESP;
         RESP:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         last_grant <= 1'b1;
         grant_q    <= 1'b0;
      end else if (take) begin
         last_grant <= arb_idx;
         grant_q    <= arb_idx;
      end
   end

   always_ff @(posedge clk) begin
      if (take) begin
         addr_q  <= arb_idx ? p1.addr  : p0.addr;
         wr_q    <= arb_idx ? p1.wr    : p0.wr;
         be_q    <= arb_idx ? p1.be    : p0.be;
         wdata_q <= arb_idx ? p1.wdata : p0.wdata;
      end
   end

   // Ack is combinational from state so a reset during RESP still shows it.
   always_comb begin
      ram_wen = BE_NONE;
      p0.ack  = 1'b0;
      p1.ack  = 1'b0;
      case (state)
         ACCESS: ram_wen = access_wen(wr_q, be_q);
         RESP: begin
            p0.ack = ~grant_q;
            p1.ack = grant_q;
         end
         default: ram_wen = BE_NONE;
      endcase
   end

   assign ram_addr  = addr_q;
   assign ram_wdata = wdata_q;
   assign p0.rdata  = ram_rdata;
   assign p1.rdata  = ram_rdata;
   assign busy      = (state != IDLE);
   assign grant     = grant_q;

endmodule

// File: tb/tb_spram_arbiter.sv
// Bench for spram_arbiter: a round-robin and a fixed-priority instance, each
// with its own SPRAM model, checked every cycle against a transaction model.
module tb_spram_arbiter;
   import fetchie_mem_pkg::*;

   localparam int unsigned AW    = SPRAM_ADDR_W;
   localparam int unsigned DEPTH = 64;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   // index [d][p]: d = 0 round-robin DUT, d = 1 fixed-priority DUT
   logic          req_v   [2][2];
   logic          wr_v    [2][2];
   logic [3:0]    be_v    [2][2];
   logic [AW-1:0] addr_v  [2][2];
   logic [31:0]   wdata_v [2][2];
   logic          ack_w   [2][2];
   logic [31:0]   rdata_w [2][2];

   logic [AW-1:0] ram_addr_w  [2];
   logic [3:0]    ram_wen_w   [2];
   logic [31:0]   ram_wdata_w [2];
   logic [31:0]   ram_rdata_r [2];
   logic          busy_w      [2];
   logic          grant_w     [2];

   spram_arbiter_if #(.ADDR_W(AW)) rr_p0 ();
   spram_arbiter_if #(.ADDR_W(AW)) rr_p1 ();
   spram_arbiter_if #(.ADDR_W(AW)) fp_p0 ();
   spram_arbiter_if #(.ADDR_W(AW)) fp_p1 ();

   assign rr_p0.req = req_v[0][0];  assign rr_p0.wr = wr_v[0][0];  assign rr_p0.be = be_v[0][0];
   assign rr_p0.addr = addr_v[0][0]; assign rr_p0.wdata = wdata_v[0][0];
   assign rr_p1.req = req_v[0][1];  assign rr_p1.wr = wr_v[0][1];  assign rr_p1.be = be_v[0][1];
   assign rr_p1.addr = addr_v[0][1]; assign rr_p1.wdata = wdata_v[0][1];
   assign fp_p0.req = req_v[1][0];  assign fp_p0.wr = wr_v[1][0];  assign fp_p0.be = be_v[1][0];
   assign fp_p0.addr = addr_v[1][0]; assign fp_p0.wdata = wdata_v[1][0];
   assign fp_p1.req = req_v[1][1];  assign fp_p1.wr = wr_v[1][1];  assign fp_p1.be = be_v[1][1];
   assign fp_p1.addr = addr_v[1][1]; assign fp_p1.wdata = wdata_v[1][1];
   assign ack_w[0][0] = rr_p0.ack;  assign rdata_w[0][0] = rr_p0.rdata;
   assign ack_w[0][1] = rr_p1.ack;  assign rdata_w[0][1] = rr_p1.rdata;
   assign ack_w[1][0] = fp_p0.ack;  assign rdata_w[1][0] = fp_p0.rdata;
   assign ack_w[1][1] = fp_p1.ack;  assign rdata_w[1][1] = fp_p1.rdata;

   spram_arbiter #(.ADDR_W(AW), .FIXED_PRIO(0)) dut_rr (
      .clk(clk), .reset(reset), .p0(rr_p0), .p1(rr_p1),
      .ram_addr(ram_addr_w[0]), .ram_wen(ram_wen_w[0]), .ram_wdata(ram_wdata_w[0]),
      .ram_rdata(ram_rdata_r[0]), .busy(busy_w[0]), .grant(grant_w[0])
   );

   spram_arbiter #(.ADDR_W(AW), .FIXED_PRIO(1)) dut_fp (
      .clk(clk), .reset(reset), .p0(fp_p0), .p1(fp_p1),
      .ram_addr(ram_addr_w[1]), .ram_wen(ram_wen_w[1]), .ram_wdata(ram_wdata_w[1]),
      .ram_rdata(ram_rdata_r[1]), .busy(busy_w[1]), .grant(grant_w[1])
   );

   // SPRAM models: byte-masked write, registered read, optional preload
   logic [31:0] ram_mem   [2][DEPTH];
   logic [31:0] init_vals [DEPTH];
   logic        pre_en;

   always @(posedge clk) begin
      for (int d = 0; d < 2; d++) begin
         for (int b = 0; b < 4; b++)
            if (ram_wen_w[d][b]) ram_mem[d][ram_addr_w[d][5:0]][8*b +: 8] <= ram_wdata_w[d][8*b +: 8];
         ram_rdata_r[d] <= ram_mem[d][ram_addr_w[d][5:0]];
      end
      if (pre_en)
         for (int a = 0; a < DEPTH; a++) begin
            ram_mem[0][a] <= init_vals[a];
            ram_mem[1][a] <= init_vals[a];
         end
   end

   // Transaction model: grant cycle g, write on edge g+1, ack in cycle g+2
   int          cyc;
   int          m_free [2];
   int          m_gcyc [2];
   logic        m_last [2];
   logic        m_gnt  [2];
   logic        m_gout [2];
   logic        m_wr   [2];
   logic [3:0]  m_be   [2];
   logic [AW-1:0] m_addr [2];
   logic [31:0] m_wdata [2];
   logic [31:0] m_rd   [2];
   logic [31:0] shadow [2][DEPTH];

   int vectors;
   int miscompares;

   logic active  [2][2];
   logic dropped [2][2];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic set_req(input int d, input int p, input logic rq, input logic wr,
                          input logic [3:0] be, input logic [AW-1:0] addr, input logic [31:0] wdata);
      req_v[d][p]   = rq;
      wr_v[d][p]    = wr;
      be_v[d][p]    = be;
      addr_v[d][p]  = addr;
      wdata_v[d][p] = wdata;
   endtask

   // Model the decision at the end of this cycle, cross the edge, check all outputs.
   task automatic step();
      logic       w;
      logic       exp_ack;
      logic [3:0] exp_wen;
      for (int d = 0; d < 2; d++) begin
         if (reset) begin
            if (m_gcyc[d] + 2 > cyc) m_gcyc[d] = -100;
            m_free[d] = cyc + 1;
            m_last[d] = 1'b1;
            m_gout[d] = 1'b0;
         end else if (cyc >= m_free[d] && (req_v[d][0] || req_v[d][1])) begin
            if (req_v[d][0] && req_v[d][1]) w = (d == 1) ? 1'b0 : ~m_last[d];
            else                            w = req_v[d][1];
            m_last[d]  = w;
            m_gnt[d]   = w;
            m_gout[d]  = w;
            m_gcyc[d]  = cyc;
            m_free[d]  = cyc + 3;
            m_wr[d]    = wr_v[d][w];
            m_be[d]    = be_v[d][w];
            m_addr[d]  = addr_v[d][w];
            m_wdata[d] = wdata_v[d][w];
            if (m_wr[d]) begin
               for (int b = 0; b < 4; b++)
                  if (m_be[d][b]) shadow[d][m_addr[d][5:0]][8*b +: 8] = m_wdata[d][8*b +: 8];
            end else begin
               m_rd[d] = shadow[d][m_addr[d][5:0]];
            end
         end
      end
      @(posedge clk);
      #1;
      cyc++;
      for (int d = 0; d < 2; d++) begin
         for (int p = 0; p < 2; p++) begin
            exp_ack = (cyc == m_gcyc[d] + 2) && (m_gnt[d] == p[0]);
            chk($sformatf("d%0d_ack%0d_c%0d", d, p, cyc), 32'(ack_w[d][p]), 32'(exp_ack));
            if (exp_ack && !m_wr[d])
               chk($sformatf("d%0d_rdata%0d_c%0d", d, p, cyc), rdata_w[d][p], m_rd[d]);
         end
         exp_wen = (cyc == m_gcyc[d] + 1 && m_wr[d]) ? m_be[d] : 4'b0000;
         chk($sformatf("d%0d_wen_c%0d", d, cyc), 32'(ram_wen_w[d]), 32'(exp_wen));
         if (exp_wen != 4'b0000) begin
            chk($sformatf("d%0d_waddr_c%0d", d, cyc), 32'(ram_addr_w[d]), 32'(m_addr[d]));
            chk($sformatf("d%0d_wdata_c%0d", d, cyc), ram_wdata_w[d], m_wdata[d]);
         end
         chk($sformatf("d%0d_busy_c%0d", d, cyc), 32'(busy_w[d]),
             32'((cyc > m_gcyc[d]) && (cyc <= m_gcyc[d] + 2)));
         chk($sformatf("d%0d_grant_c%0d", d, cyc), 32'(grant_w[d]), 32'(m_gout[d]));
      end
   endtask

   initial begin
      int t0;
      int k;
      vectors     = 0;
      miscompares = 0;
      cyc         = 0;
      for (int d = 0; d < 2; d++) begin
         m_free[d] = 0;   m_gcyc[d] = -100; m_last[d] = 1'b1; m_gnt[d] = 1'b0;
         m_gout[d] = 1'b0; m_wr[d] = 1'b0;  m_be[d] = '0;     m_addr[d] = '0;
         m_wdata[d] = '0; m_rd[d] = '0;
         for (int p = 0; p < 2; p++) begin
            set_req(d, p, 1'b0, 1'b0, 4'h0, '0, '0);
            active[d][p]  = 1'b0;
            dropped[d][p] = 1'b0;
         end
      end
      for (int a = 0; a < DEPTH; a++) init_vals[a] = $urandom;
      init_vals[6'h10] = 32'hDEADBEEF;
      init_vals[6'h20] = 32'hFFFFFFFF;
      for (int a = 0; a < DEPTH; a++) begin
         shadow[0][a] = init_vals[a];
         shadow[1][a] = init_vals[a];
      end

      // reset with SPRAM preload
      reset  = 1'b1;
      pre_en = 1'b1;
      step();
      pre_en = 1'b0;
      step();
      reset = 1'b0;
      chk("rst_busy", 32'(busy_w[0]), 32'd0);
      chk("rst_grant", 32'(grant_w[0]), 32'd0);
      chk("rst_wen", 32'(ram_wen_w[0]), 32'd0);
      step();

      // single read from port 0
      set_req(0, 0, 1'b1, 1'b0, 4'h0, 14'h0010, 32'h0);
      step();
      chk("rd_ack_c1", 32'(ack_w[0][0]), 32'd0);
      step();
      chk("rd_ack_c2", 32'(ack_w[0][0]), 32'd1);
      chk("rd_data", rdata_w[0][0], 32'hDEADBEEF);
      set_req(0, 0, 1'b0, 1'b0, 4'h0, '0, '0);
      step();

      // byte write from port 1, then read back
      set_req(0, 1, 1'b1, 1'b1, 4'b0011, 14'h0020, 32'h1234ABCD);
      step();
      chk("bw_wen_access", 32'(ram_wen_w[0]), 32'h3);
      step();
      chk("bw_ack", 32'(ack_w[0][1]), 32'd1);
      chk("bw_wen_resp", 32'(ram_wen_w[0]), 32'd0);
      set_req(0, 1, 1'b0, 1'b0, 4'h0, '0, '0);
      step();
      set_req(0, 1, 1'b1, 1'b0, 4'h0, 14'h0020, 32'h0);
      step();
      step();
      chk("bw_readback", rdata_w[0][1], 32'hFFFFABCD);
      set_req(0, 1, 1'b0, 1'b0, 4'h0, '0, '0);
      step();

      // continuous contention on both instances
      reset = 1'b1;
      step();
      reset = 1'b0;
      t0 = cyc;
      for (int d = 0; d < 2; d++) begin
         set_req(d, 0, 1'b1, 1'b0, 4'h0, 14'h0001, 32'h0);
         set_req(d, 1, 1'b1, 1'b0, 4'h0, 14'h0002, 32'h0);
      end
      for (int i = 0; i < 15; i++) begin
         step();
         k = cyc - t0;
         if (k % 3 == 2 && k <= 11) begin
            chk($sformatf("rr_ack%0d_k%0d", (k / 3) % 2, k), 32'(ack_w[0][(k / 3) % 2]), 32'd1);
            chk($sformatf("rr_nack%0d_k%0d", 1 - (k / 3) % 2, k), 32'(ack_w[0][1 - (k / 3) % 2]), 32'd0);
            chk($sformatf("fp_ack0_k%0d", k), 32'(ack_w[1][0]), 32'd1);
            chk($sformatf("fp_nack1_k%0d", k), 32'(ack_w[1][1]), 32'd0);
         end
         if (k == 11) set_req(1, 0, 1'b0, 1'b0, 4'h0, '0, '0);
         if (k == 14) chk("fp_p1_after_drop", 32'(ack_w[1][1]), 32'd1);
      end
      for (int d = 0; d < 2; d++)
         for (int p = 0; p < 2; p++) set_req(d, p, 1'b0, 1'b0, 4'h0, '0, '0);
      repeat (3) step();

      // reset on the edge ending ACCESS of a write
      set_req(0, 0, 1'b1, 1'b1, 4'hF, 14'h0003, 32'h55AA55AA);
      step();
      set_req(0, 0, 1'b0, 1'b0, 4'h0, '0, '0);
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("rw_no_ack", 32'(ack_w[0][0]), 32'd0);
      chk("rw_busy", 32'(busy_w[0]), 32'd0);
      chk("rw_wen", 32'(ram_wen_w[0]), 32'd0);
      set_req(0, 0, 1'b1, 1'b0, 4'h0, 14'h0003, 32'h0);
      step();
      step();
      chk("rw_readback_ack", 32'(ack_w[0][0]), 32'd1);
      chk("rw_readback", rdata_w[0][0], 32'h55AA55AA);
      set_req(0, 0, 1'b0, 1'b0, 4'h0, '0, '0);
      step();

      // port 0 drops req during ACCESS while port 1 is pending
      set_req(0, 0, 1'b1, 1'b0, 4'h0, 14'h0005, 32'h0);
      step();
      set_req(0, 0, 1'b0, 1'b0, 4'h0, '0, '0);
      set_req(0, 1, 1'b1, 1'b0, 4'h0, 14'h0006, 32'h0);
      step();
      chk("ed_p0_ack", 32'(ack_w[0][0]), 32'd1);
      chk("ed_p0_rdata", rdata_w[0][0], init_vals[5]);
      step();
      step();
      step();
      chk("ed_p1_ack", 32'(ack_w[0][1]), 32'd1);
      chk("ed_p1_rdata", rdata_w[0][1], init_vals[6]);
      set_req(0, 1, 1'b0, 1'b0, 4'h0, '0, '0);
      step();

      // randomized traffic with early drops and occasional reset
      for (int i = 0; i < 600; i++) begin
         reset = ($urandom_range(99) == 0);
         for (int d = 0; d < 2; d++)
            for (int p = 0; p < 2; p++) begin
               if (!active[d][p] && $urandom_range(2) == 0) begin
                  active[d][p] = 1'b1;
                  set_req(d, p, 1'b0, 1'($urandom_range(1)), 4'($urandom),
                          AW'($urandom_range(DEPTH - 1)), $urandom);
               end
               req_v[d][p] = active[d][p] && !dropped[d][p];
            end
         step();
         for (int d = 0; d < 2; d++)
            for (int p = 0; p < 2; p++) begin
               if (cyc == m_gcyc[d] + 2 && m_gnt[d] == p[0]) begin
                  active[d][p]  = 1'b0;
                  dropped[d][p] = 1'b0;
               end else if (cyc == m_gcyc[d] + 1 && m_gnt[d] == p[0] && $urandom_range(3) == 0) begin
                  dropped[d][p] = 1'b1;
               end
               if (reset) dropped[d][p] = 1'b0;
            end
      end
      reset = 1'b0;
      for (int d = 0; d < 2; d++)
         for (int p = 0; p < 2; p++) req_v[d][p] = 1'b0;
      repeat (5) step();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
